// File: rtl/hazard_fwd_sb.sv
// RAW hazard detection and operand forwarding beside decode, with a
// multi-cycle scoreboard (busy bits + outstanding count).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   src_en_i/src_addr_i   decode source enables and register numbers
//   st_*_i                per producer stage (0 = youngest) valid/wen/rd/rdy/data
//   d_advance_i, flush_i  decode advance and pipeline flush
//   mc_issue_*_i          multi-cycle op issued from decode
//   mc_done_*_i           multi-cycle op completion and result
//   stall_d_o             combinational decode stall
//   fwd_valid_o/fwd_data_o forward values per source (optionally registered)
//   mc_count_o            outstanding multi-cycle ops
//   sb_err_o              sticky: completion seen with nothing outstanding
module hazard_fwd_sb #(
    parameter int XLEN    = 32,
    parameter int NSRC    = 3,
    parameter int NSTAGE  = 3,
    parameter int MC_MAX  = 4,
    parameter int REG_OUT = 1,
    localparam int CW     = $clog2(MC_MAX + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NSRC-1:0]        src_en_i,
    input  logic [5*NSRC-1:0]      src_addr_i,
    input  logic [NSTAGE-1:0]      st_valid_i,
    input  logic [NSTAGE-1:0]      st_wen_i,
    input  logic [5*NSTAGE-1:0]    st_rd_i,
    input  logic [NSTAGE-1:0]      st_rdy_i,
    input  logic [XLEN*NSTAGE-1:0] st_data_i,
    input  logic                   d_advance_i,
    input  logic                   flush_i,
    input  logic                   mc_issue_i,
    input  logic [4:0]             mc_issue_rd_i,
    input  logic                   mc_done_i,
    input  logic [4:0]             mc_done_rd_i,
    input  logic [XLEN-1:0]        mc_done_data_i,
    output logic                   stall_d_o,
    output logic [NSRC-1:0]        fwd_valid_o,
    output logic [XLEN*NSRC-1:0]   fwd_data_o,
    output logic [CW-1:0]          mc_count_o,
    output logic                   sb_err_o
);

    logic [31:0]          busy_q, busy_d;
    logic [CW-1:0]        mc_count_q, mc_count_d;
    logic                 sb_err_q, sb_err_d;

    logic [NSRC-1:0]      fv_c;
    logic [XLEN*NSRC-1:0] fd_c;
    logic                 src_stall;
    logic                 waw_stall;
    logic                 cap_stall;
    logic                 stall;
    logic                 accept;
    logic                 dec;

    logic [4:0]           addr;
    logic                 hit;
    logic                 hrdy;
    logic [XLEN-1:0]      hdata;

    // Per source: the youngest matching stage decides; the scoreboard
    // is consulted only when no stage holds the register.
    always_comb begin
        fv_c      = '0;
        fd_c      = '0;
        src_stall = 1'b0;
        addr      = '0;
        hit       = 1'b0;
        hrdy      = 1'b0;
        hdata     = '0;
        for (int s = 0; s < NSRC; s++) begin
            addr  = src_addr_i[5*s +: 5];
            hit   = 1'b0;
            hrdy  = 1'b0;
            hdata = '0;
            for (int i = 0; i < NSTAGE; i++) begin
                if (!hit && st_valid_i[i] && st_wen_i[i] &&
                    st_rd_i[5*i +: 5] == addr) begin
                    hit   = 1'b1;
                    hrdy  = st_rdy_i[i];
                    hdata = st_data_i[XLEN*i +: XLEN];
                end
            end
            if (src_en_i[s] && addr != 5'd0) begin
                if (hit) begin
                    if (hrdy) begin
                        fv_c[s]              = 1'b1;
                        fd_c[XLEN*s +: XLEN] = hdata;
                    end else begin
                        src_stall = 1'b1;
                    end
                end else if (busy_q[addr]) begin
                    if (mc_done_i && mc_done_rd_i == addr) begin
                        fv_c[s]              = 1'b1;
                        fd_c[XLEN*s +: XLEN] = mc_done_data_i;
                    end else begin
                        src_stall = 1'b1;
                    end
                end
            end
        end
    end

    // A completion landing this cycle frees both the register and a slot.
    assign waw_stall = mc_issue_i && mc_issue_rd_i != 5'd0 &&
                       busy_q[mc_issue_rd_i] &&
                       !(mc_done_i && mc_done_rd_i == mc_issue_rd_i);
    assign cap_stall = mc_issue_i && mc_count_q == CW'(MC_MAX) &&
                       !mc_done_i;
    assign stall     = src_stall | waw_stall | cap_stall;
    assign accept    = mc_issue_i & d_advance_i & ~stall & ~flush_i;
    assign dec       = mc_done_i && mc_count_q != '0;

    // Clear before set so a same-register issue+done leaves busy set.
    always_comb begin
        busy_d = busy_q;
        if (mc_done_i)
            busy_d[mc_done_rd_i] = 1'b0;
        if (accept && mc_issue_rd_i != 5'd0)
            busy_d[mc_issue_rd_i] = 1'b1;
        mc_count_d = mc_count_q + CW'(accept) - CW'(dec);
        sb_err_d   = sb_err_q | (mc_done_i && mc_count_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            mc_count_q <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            mc_count_q <= mc_count_d;
            sb_err_q   <= sb_err_d;
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            logic [NSRC-1:0]      fv_q;
            logic [XLEN*NSRC-1:0] fd_q;

            always_ff @(posedge clk) begin
                if (rst || flush_i) begin
                    fv_q <= '0;
                    fd_q <= '0;
                end else if (d_advance_i && !stall) begin
                    fv_q <= fv_c;
                    fd_q <= fd_c;
                end
            end

            assign fwd_valid_o = fv_q;
            assign fwd_data_o  = fd_q;
        end else begin : g_comb
            assign fwd_valid_o = fv_c;
            assign fwd_data_o  = fd_c;
        end
    endgenerate

    assign stall_d_o  = stall;
    assign mc_count_o = mc_count_q;
    assign sb_err_o   = sb_err_q;

endmodule

// File: doc/hazard_fwd_sb.md
# hazard_fwd_sb

Parametrised RAW hazard detection and operand forwarding unit for the RV32 in-order pipeline, sitting beside the decode stage. It compares up to NSRC decode-stage source registers against NSTAGE downstream producer stages and a scoreboard of outstanding multi-cycle ops (div/mul/long-latency units). It then either forwards the youngest available result or stalls decode. Compared with the fixed 2-source/3-stage unit, it adds parametrised source and stage counts, per-stage data readiness, a multi-cycle scoreboard with WAW protection, and an optional registered output.

## Interface
- XLEN, 32, data width
- NSRC, 3, decode source operands (rs1, rs2, rs3)
- NSTAGE, 3, producer stages; index 0 = youngest (E), NSTAGE-1 = oldest (W)
- MC_MAX, 4, max outstanding multi-cycle ops (≥1)
- REG_OUT, 1, 1 = forward outputs registered on D advance; 0 = combinational
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- src_en  in  NSRC  source s is read by the decode instruction
- src_addr  in  5*NSRC  source register numbers, s at [5s+4:5s]
- st_valid  in  NSTAGE  stage holds a live instruction
- st_wen  in  NSTAGE  stage instruction writes rd
- st_rd  in  5*NSTAGE  stage destination registers
- st_rdy  in  NSTAGE  stage result is already computed (0 for a load in E, etc.)
- st_data  in  XLEN*NSTAGE  stage result data
- d_advance  in  1  decode instruction moves to E this cycle (already qualified by top-level)
- flush  in  1  pipeline flush
- mc_issue  in  1  decode instruction is a multi-cycle op
- mc_issue_rd  in  5  its destination
- mc_done  in  1  multi-cycle op completes this cycle
- mc_done_rd  in  5  completing destination
- mc_done_data  in  XLEN  completing result
- stall_d  out  1  hold decode (combinational)
- fwd_valid  out  NSRC  forward value valid for source s
- fwd_data  out  XLEN*NSRC  forward values
- mc_count  out  $clog2(MC_MAX+1)  outstanding multi-cycle ops
- sb_err  out  1  sticky: mc_done received with mc_count==0

## Operation
- Stage match i,s: st_valid[i] & st_wen[i] & st_rd[i]!=0 & st_rd[i]==src_addr[s] & src_en[s].
- Per source s, take the lowest matching i. st_rdy[i]=1 → forward st_data[i]. st_rdy[i]=0 → source stall. Older stages are ignored once a younger stage matches.
- No stage match and busy[src_addr[s]]=1: if mc_done & mc_done_rd==src_addr[s], forward mc_done_data; otherwise source stall.
- Source address 0 or src_en[s]=0 never matches, never stalls, and gives fwd_valid[s]=0, data 0.
- WAW stall: mc_issue & mc_issue_rd!=0 & busy[mc_issue_rd] & ~(mc_done & mc_done_rd==mc_issue_rd).
- Capacity stall: mc_issue & mc_count==MC_MAX & ~mc_done.
- stall_d = OR of source stalls, WAW stall and capacity stall.
- Issue accepted when mc_issue & d_advance & ~stall_d & ~flush. It sets busy[mc_issue_rd] when rd≠0 and always increments mc_count.
- mc_done clears busy[mc_done_rd] and decrements mc_count. Same-cycle issue+done: count unchanged. If the rd is the same, busy ends set (issue wins).
- mc_done at count 0: count stays 0 and sb_err sets (cleared only by rst).
- flush does not clear busy or mc_count; in-flight ops still complete. flush clears registered fwd outputs.

## Timing
- Reset: busy all 0, mc_count=0, sb_err=0, registered fwd_valid=0, fwd_data=0.
- stall_d is always combinational, same cycle.
- REG_OUT=0: fwd_* combinational, same cycle as decode.
- REG_OUT=1: fwd_* are captured at the edge where d_advance & ~stall_d, and are valid the following cycle (the instruction's E cycle). Otherwise they hold, except flush, which zeroes them. flush takes priority over capture.
- Scoreboard updates at the clock edge; busy set by an issue is visible to the decode instruction in the next cycle.
- rst asserted mid-operation discards all outstanding state; any later mc_done raises sb_err.

## Test plan
- Back-to-back ALU x5=… then add x6,x5,x5 with E holding rd=5, st_rdy=1, data 0x1234 → stall_d=0; fwd_valid=3'b011, both values 0x1234 (next cycle if REG_OUT=1).
- Load to x7 in E (st_rdy=0) plus older W writing x7=0xAA; decode reads x7 → stall_d=1 (youngest wins, W ignored); next cycle with M rdy data 0xBB → forward 0xBB.
- Issue div to x9, then decode reads x9 → stall for N cycles; mc_done rd=9 data 0xDEAD → stall_d=0, forward 0xDEAD in the same cycle; busy[9] clear afterwards.
- MC_MAX=2: issue to x1 and x2, then third issue to x3 → stall_d=1; same cycle mc_done → stall drops, mc_count stays 2.
- Issue to x4 while busy[4] → WAW stall; with concurrent mc_done rd=4 → accepted, busy[4]=1.
- mc_done with count 0 → sb_err=1 sticky; flush with REG_OUT=1 → fwd_valid=0 next cycle, mc_count unchanged.
